// File: rtl/cache_arbiter_if.sv
// I-cache / D-cache / physical-memory signal bundle for the cache arbiter.
// The slave modport is the arbiter side; master is the surrounding system.
interface cache_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;

  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write,
    input  d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write,
    output pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write,
    output d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write,
    input  pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical memory port between the
// I-cache and D-cache; one transaction in flight, registered outputs.
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input logic           clk,
  input logic           rst,
  cache_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [1:0]        state;
  logic              last_grant;
  logic              rd_q;
  logic              wr_q;
  logic              i_resp_q;
  logic              d_resp_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;

  logic i_req;
  logic d_req;
  logic grant_d;
  logic grant_i;

  assign i_req = bus.i_pmem_read;
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;

  // On a tie the side that did not win last time goes first.
  assign grant_d = d_req & (~i_req | (last_grant == OWN_I));
  assign grant_i = i_req & ~grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= OWN_D;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      i_resp_q   <= 1'b0;
      d_resp_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            grant_d: begin
              addr_q  <= bus.d_pmem_address;
              wdata_q <= bus.d_pmem_wdata;
              wr_q    <= bus.d_pmem_write;
              rd_q    <= ~bus.d_pmem_write;
              state   <= SERVE_D;
            end
            grant_i: begin
              addr_q <= bus.i_pmem_address;
              wr_q   <= 1'b0;
              rd_q   <= 1'b1;
              state  <= SERVE_I;
            end
            default: ;
          endcase
        end
        SERVE_I, SERVE_D: begin
          if (bus.pmem_resp) begin
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            last_grant <= (state == SERVE_D);
            state      <= RESP;
            if (state == SERVE_D) begin
              d_rdata_q <= bus.pmem_rdata;
              d_resp_q  <= 1'b1;
            end else begin
              i_rdata_q <= bus.pmem_rdata;
              i_resp_q  <= 1'b1;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pmem_read    = rd_q;
  assign bus.pmem_write   = wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
  assign bus.i_pmem_rdata = i_rdata_q;
  assign bus.i_pmem_resp  = i_resp_q;
  assign bus.d_pmem_rdata = d_rdata_q;
  assign bus.d_pmem_resp  = d_resp_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: requester tasks push expectations,
// a memory model serves the shared port, a monitor pops on each resp.
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic          wr;
    logic [LW-1:0] data;
  } exp_t;

  exp_t i_q[$];
  exp_t d_q[$];
  int   grant_log[$];
  logic [AW-1:0] addr_log[$];

  logic [LW-1:0] mem     [logic [AW-1:0]];
  logic [LW-1:0] ref_mem [logic [AW-1:0]];

  int checks = 0;
  int errors = 0;

  int fix_delay = 0;
  bit mem_off   = 1'b0;
  bit pend_i    = 1'b0;
  bit pend_d    = 1'b0;
  int i_skip    = 0;
  int d_skip    = 0;

  logic [AW-1:0] i_cur_addr;
  logic [AW-1:0] d_cur_addr;
  logic          d_cur_wr;
  logic [LW-1:0] d_cur_wdata;

  logic          mem_resp  = 1'b0;
  logic          spur_resp = 1'b0;
  logic [LW-1:0] mem_rdata = '0;
  assign bus.pmem_resp  = mem_resp | spur_resp;
  assign bus.pmem_rdata = mem_rdata;

  task automatic chk(input string nm, input logic [LW-1:0] act,
                     input logic [LW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
    logic [LW-1:0] r;
    r = '0;
    for (int i = 0; i < LW / 32; i++)
      r[i*32 +: 32] = (a ^ 32'hC0DE_0000) + 32'(i) * 32'h0101_0101;
    return r;
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Memory: contents default to pat(addr); a write returns ~wdata.
  initial begin : memory_model
    logic [AW-1:0] ma;
    logic          mwr;
    logic [LW-1:0] mwd;
    int            k;
    int            hi;
    int            own;
    forever begin
      @(negedge clk);
      mem_rdata = rnd_line();
      if (!mem_off && !rst && (bus.pmem_read || bus.pmem_write)) begin
        ma  = bus.pmem_address;
        mwr = bus.pmem_write;
        mwd = bus.pmem_wdata;
        chk("op_onehot", LW'(bus.pmem_read ^ bus.pmem_write), 1);
        if (pend_i && !mwr && ma == i_cur_addr) own = 0;
        else if (pend_d && ma == d_cur_addr && mwr == d_cur_wr &&
                 (!mwr || mwd == d_cur_wdata)) own = 1;
        else own = -1;
        checks++;
        if (own < 0) begin
          errors++;
          $display("FAIL grant_match got addr %0h wr %0b", ma, mwr);
        end
        grant_log.push_back(own);
        addr_log.push_back(ma);
        if (own == 0) begin
          i_skip = 0;
          if (pend_d) begin
            d_skip++;
            chk("fair_d", LW'(d_skip <= 1), 1);
          end
        end else if (own == 1) begin
          d_skip = 0;
          if (pend_i) begin
            i_skip++;
            chk("fair_i", LW'(i_skip <= 1), 1);
          end
        end
        k  = (fix_delay > 0) ? fix_delay : int'($urandom_range(1, 5));
        hi = 1;
        while (hi < k) begin
          @(negedge clk);
          mem_rdata = rnd_line();
          chk("hold_addr", LW'(bus.pmem_address), LW'(ma));
          chk("hold_op", LW'({bus.pmem_read, bus.pmem_write}),
              LW'({~mwr, mwr}));
          if (mwr) chk("hold_wdata", bus.pmem_wdata, mwd);
          hi++;
        end
        if (mwr) mem[ma] = mwd;
        mem_rdata = mwr ? ~mwd : (mem.exists(ma) ? mem[ma] : pat(ma));
        mem_resp  = 1'b1;
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = rnd_line();
        chk("rw_low_after_resp",
            LW'({bus.pmem_read, bus.pmem_write}), 0);
      end
    end
  end

  initial begin : monitor
    logic          prev_i;
    logic          prev_d;
    logic [LW-1:0] last_i;
    logic [LW-1:0] last_d;
    exp_t          e;
    prev_i = 1'b0;
    prev_d = 1'b0;
    last_i = '0;
    last_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_i = '0;
        last_d = '0;
        prev_i = 1'b0;
        prev_d = 1'b0;
      end else begin
        chk("resp_excl", LW'(bus.i_pmem_resp & bus.d_pmem_resp), 0);
        if (bus.i_pmem_resp) begin
          checks++;
          if (prev_i || i_q.size() == 0) begin
            errors++;
            $display("FAIL i_resp_unexpected got 1 want 0");
          end else begin
            e = i_q.pop_front();
            last_i = e.data;
          end
        end
        chk("i_rdata", bus.i_pmem_rdata, last_i);
        if (bus.d_pmem_resp) begin
          checks++;
          if (prev_d || d_q.size() == 0) begin
            errors++;
            $display("FAIL d_resp_unexpected got 1 want 0");
          end else begin
            e = d_q.pop_front();
            last_d = e.data;
          end
        end
        chk("d_rdata", bus.d_pmem_rdata, last_d);
        prev_i = bus.i_pmem_resp;
        prev_d = bus.d_pmem_resp;
      end
    end
  end

  task automatic do_i(input logic [AW-1:0] a);
    exp_t e;
    int   n;
    e.wr   = 1'b0;
    e.data = pat(a);
    i_q.push_back(e);
    i_cur_addr         = a;
    pend_i             = 1'b1;
    bus.i_pmem_address = a;
    bus.i_pmem_read    = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.i_pmem_resp && n < 300);
    if (!bus.i_pmem_resp) begin
      checks++;
      errors++;
      $display("FAIL i_timeout got no resp want resp");
    end
    bus.i_pmem_read    = 1'b0;
    bus.i_pmem_address = $urandom;
    pend_i             = 1'b0;
  endtask

  task automatic do_d(input logic [AW-1:0] a, input logic wr,
                      input logic both, input logic [LW-1:0] wd,
                      input logic glitch);
    exp_t e;
    int   n;
    e.wr = wr;
    if (wr) begin
      ref_mem[a] = wd;
      e.data     = ~wd;
    end else begin
      e.data = ref_mem.exists(a) ? ref_mem[a] : pat(a);
    end
    d_q.push_back(e);
    d_cur_addr         = a;
    d_cur_wr           = wr;
    d_cur_wdata        = wd;
    pend_d             = 1'b1;
    bus.d_pmem_address = a;
    bus.d_pmem_wdata   = wd;
    bus.d_pmem_write   = wr;
    bus.d_pmem_read    = !wr || both;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (glitch && n == 2) begin
        bus.d_pmem_address = 32'hDEAD_BEE0;
        bus.d_pmem_wdata   = ~wd;
      end
    end while (!bus.d_pmem_resp && n < 300);
    if (!bus.d_pmem_resp) begin
      checks++;
      errors++;
      $display("FAIL d_timeout got no resp want resp");
    end
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_address = $urandom;
    pend_d             = 1'b0;
  endtask

  task automatic run_i(input int n);
    repeat (n) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_i(32'h1000 + (AW'($urandom_range(0, 15)) << 5));
    end
  endtask

  task automatic run_d(input int n);
    logic [AW-1:0] a;
    repeat (n) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = ($urandom_range(0, 3) == 0) ? 32'h3020
        : 32'h2000 + (AW'($urandom_range(0, 15)) << 5);
      do_d(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           rnd_line(), 1'b0);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    bus.i_pmem_read    = 1'b0;
    bus.i_pmem_address = '0;
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_wdata   = '0;
    repeat (3) @(negedge clk);
    chk("rst_pmem_read", LW'(bus.pmem_read), 0);
    chk("rst_pmem_write", LW'(bus.pmem_write), 0);
    chk("rst_pmem_address", LW'(bus.pmem_address), 0);
    chk("rst_pmem_wdata", bus.pmem_wdata, 0);
    chk("rst_i_resp", LW'(bus.i_pmem_resp), 0);
    chk("rst_d_resp", LW'(bus.d_pmem_resp), 0);
    chk("rst_i_rdata", bus.i_pmem_rdata, 0);
    chk("rst_d_rdata", bus.d_pmem_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    fix_delay = 2;
    base = grant_log.size();
    fork
      do_i(32'h0000_1000);
      do_d(32'h0000_2000, 1'b0, 1'b0, '0, 1'b0);
    join
    chk("tie1_owner", LW'(grant_log[base]), 0);
    chk("tie1_addr", LW'(addr_log[base]), LW'(32'h0000_1000));
    chk("tie1_next_addr", LW'(addr_log[base+1]), LW'(32'h0000_2000));
    fix_delay = 0;

    fork
      do_i(32'h0000_1020);
      do_d(32'h0000_2020, 1'b0, 1'b0, '0, 1'b0);
    join
    chk("alt_0", LW'(grant_log[base+1]), 1);
    chk("alt_1", LW'(grant_log[base+2]), 0);
    chk("alt_2", LW'(grant_log[base+3]), 1);

    do_i(32'h0000_1040);
    base = grant_log.size();
    fork
      do_i(32'h0000_1060);
      do_d(32'h0000_2040, 1'b0, 1'b0, '0, 1'b0);
    join
    chk("tie_after_i", LW'(grant_log[base]), 1);

    fix_delay = 5;
    base = grant_log.size();
    do_d(32'h0000_3020, 1'b1, 1'b1, {32{8'hA5}}, 1'b1);
    chk("wr_addr", LW'(addr_log[base]), LW'(32'h0000_3020));
    fix_delay = 0;

    mem_off = 1'b1;
    @(negedge clk);
    bus.i_pmem_address = 32'h0000_1060;
    bus.i_pmem_read    = 1'b1;
    @(negedge clk);
    chk("pre_rst_read", LW'(bus.pmem_read), 1);
    chk("pre_rst_addr", LW'(bus.pmem_address), LW'(32'h0000_1060));
    #2;
    rst = 1'b1;
    bus.i_pmem_read = 1'b0;
    #1;
    chk("async_rst_read", LW'(bus.pmem_read), 0);
    chk("async_rst_addr", LW'(bus.pmem_address), 0);
    spur_resp = 1'b1;
    @(negedge clk);
    chk("rst_no_i_resp", LW'(bus.i_pmem_resp), 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("spur_read", LW'(bus.pmem_read), 0);
      chk("spur_i_resp", LW'(bus.i_pmem_resp), 0);
      chk("spur_d_resp", LW'(bus.d_pmem_resp), 0);
    end
    spur_resp = 1'b0;
    mem_off   = 1'b0;

    base = grant_log.size();
    fork
      do_i(32'h0000_1080);
      do_d(32'h0000_2080, 1'b0, 1'b0, '0, 1'b0);
    join
    chk("post_rst_tie", LW'(grant_log[base]), 0);

    fork
      run_i(40);
      run_d(40);
    join

    repeat (5) @(negedge clk);
    chk("i_q_empty", LW'(i_q.size()), 0);
    chk("d_q_empty", LW'(d_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
